// File: rtl/sched_pkg.sv
// Shared sizing helpers for the statically scheduled datapath primitives.
// Counter widths hold 0..depth inclusive; pointer widths index 0..depth-1.
package sched_pkg;

    function automatic int sched_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry store still needs a one-bit pointer
    function automatic int sched_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sched_valid_pipe.sv
// Delays a go pulse by DELAY cycles to produce the capture strobe; DELAY=0 is a wire.
// Fixed latency DELAY, no backpressure: every pulse entering emerges DELAY cycles later.
module sched_valid_pipe #(
    parameter int DELAY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    output logic strobe
);

    if (DELAY == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign strobe = go;
    end else begin : g_pipe
        logic [DELAY-1:0] pipe_q;
        logic [DELAY-1:0] pipe_d;

        // Stage k holds the invocation started k+1 cycles ago
        always_comb begin
            pipe_d    = pipe_q;
            pipe_d[0] = go;
            for (int k = 1; k < DELAY; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign strobe = pipe_q[DELAY-1];
    end

endmodule

// File: rtl/sched_output_collector.sv
// Captures data_in DELAY cycles after each accepted go into a DEPTH-entry FIFO; 1-cycle capture-to-output.
// Credit-based: can_go stays low until every in-flight and queued result has storage; head held while out_ready low.
module sched_output_collector
    import sched_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DELAY = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic             can_go,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow
);

    localparam int CNT_W = sched_cnt_w(DEPTH);
    localparam int PTR_W = sched_ptr_w(DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    cnt_t             in_flight_q, in_flight_d;
    cnt_t             occ_q, occ_d;
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             go_acc;
    logic             strobe;
    logic             pop;
    logic [CNT_W:0]   credit_used;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit looks only at registered counts, so a same-cycle pop is credited next cycle
    assign credit_used = {1'b0, in_flight_q} + {1'b0, occ_q};
    assign can_go      = credit_used < (CNT_W+1)'(DEPTH);
    assign go_acc      = go && can_go;
    assign out_valid   = (occ_q != '0);
    assign pop         = out_valid && out_ready;
    assign out_data    = mem_q[head_q];
    assign overflow    = overflow_q;

    sched_valid_pipe #(
        .DELAY (DELAY)
    ) u_valid_pipe (
        .clk    (clk),
        .reset  (reset),
        .go     (go_acc),
        .strobe (strobe)
    );

    always_comb begin
        in_flight_d = in_flight_q;
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        overflow_d  = overflow_q || (go && !can_go);
        mem_d       = mem_q;

        if (go_acc && !strobe) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!go_acc && strobe) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end

        if (strobe && !pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!strobe && pop) begin
            occ_d = occ_q - CNT_W'(1);
        end

        if (strobe) begin
            mem_d[tail_q] = data_in;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight_q <= '0;
            occ_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            in_flight_q <= in_flight_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
        end
    end

    // Credit guarantees a capture always finds a free slot
    a_capture_not_full: assert property (@(posedge clk) disable iff (reset)
        strobe |-> (occ_q < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_sched_output_collector.sv
// Bench for sched_output_collector: three configurations (2/4, 0/1, 3/5) against a queue model plus
// directed literal expectations for latency, credit, overflow, wrap and reset behaviour.
module tb_sched_output_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        go_v     [3];
    logic [31:0] din_v    [3];
    logic        rdy_v    [3];
    logic        can_go_v [3];
    logic        ov_v     [3];
    logic [31:0] od_v     [3];
    logic        of_v     [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int D = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
        localparam int N = (g == 0) ? 4 : ((g == 1) ? 1 : 5);

        sched_output_collector #(
            .WIDTH (32),
            .DELAY (D),
            .DEPTH (N)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .go        (go_v[g]),
            .data_in   (din_v[g]),
            .can_go    (can_go_v[g]),
            .out_valid (ov_v[g]),
            .out_ready (rdy_v[g]),
            .out_data  (od_v[g]),
            .overflow  (of_v[g])
        );

        // Model: pending capture times of accepted invocations, and the queue of captured values
        int          pend[$];
        logic [31:0] fq[$];
        bit          movf    = 1'b0;
        bit          started = 1'b0;
        int          cyc     = 0;

        always @(posedge clk) begin
            if (reset) begin
                pend.delete();
                fq.delete();
                movf    = 1'b0;
                started = 1'b1;
            end else begin
                bit credit;
                credit = (pend.size() + fq.size()) < N;
                if (go_v[g]) begin
                    if (credit) pend.push_back(cyc + D);
                    else movf = 1'b1;
                end
                if (fq.size() > 0 && rdy_v[g]) void'(fq.pop_front());
                if (pend.size() > 0 && pend[0] == cyc) begin
                    fq.push_back(din_v[g]);
                    void'(pend.pop_front());
                end
            end
            cyc++;
        end

        always @(negedge clk) begin
            if (started) begin
                chk($sformatf("i%0d_can_go", g), 32'(can_go_v[g]), 32'((pend.size() + fq.size()) < N));
                chk($sformatf("i%0d_out_valid", g), 32'(ov_v[g]), 32'(fq.size() != 0));
                chk($sformatf("i%0d_overflow", g), 32'(of_v[g]), 32'(movf));
                if (fq.size() != 0) chk($sformatf("i%0d_out_data", g), od_v[g], fq[0]);
            end
        end
    end

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            go_v[k]  = 1'b0;
            din_v[k] = 32'h0;
            rdy_v[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int acc;
        int npop;
        int first_v;
        int last_v;
        bit drop;

        idle_all();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_can_go", 32'(can_go_v[k]), 32'd1);
            chk("rst_out_valid", 32'(ov_v[k]), 32'd0);
            chk("rst_overflow", 32'(of_v[k]), 32'd0);
            chk("rst_out_data", od_v[k], 32'd0);
        end

        // Single invocation, DELAY=2
        go_v[0] = 1'b1;
        @(negedge clk); go_v[0] = 1'b0;
        @(negedge clk); din_v[0] = 32'hA5;
        @(negedge clk); din_v[0] = 32'h0;
        chk("t1_valid", 32'(ov_v[0]), 32'd1);
        chk("t1_data", od_v[0], 32'hA5);
        rdy_v[0] = 1'b1;
        @(negedge clk);
        chk("t1_valid_after_pop", 32'(ov_v[0]), 32'd0);
        rdy_v[0] = 1'b0;

        // DELAY=0, DEPTH=1 credit loop
        do_reset();
        go_v[1] = 1'b1; din_v[1] = 32'h11;
        @(negedge clk); go_v[1] = 1'b0; din_v[1] = 32'h0;
        chk("t2_valid", 32'(ov_v[1]), 32'd1);
        chk("t2_data", od_v[1], 32'h11);
        chk("t2_can_go_held", 32'(can_go_v[1]), 32'd0);
        @(negedge clk);
        chk("t2_can_go_at_pop", 32'(can_go_v[1]), 32'd0);
        rdy_v[1] = 1'b1;
        @(negedge clk);
        chk("t2_can_go_after_pop", 32'(can_go_v[1]), 32'd1);
        chk("t2_valid_after_pop", 32'(ov_v[1]), 32'd0);
        rdy_v[1] = 1'b0;

        // Fill with out_ready low, then force an overflow
        do_reset();
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            go_v[0]  = can_go_v[0];
            din_v[0] = 32'h100 + 32'(c);
            if (go_v[0] && can_go_v[0]) acc++;
            @(negedge clk);
        end
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_can_go_low", 32'(can_go_v[0]), 32'd0);
        go_v[0] = 1'b1;
        @(negedge clk);
        go_v[0] = 1'b0;
        chk("t3_overflow", 32'(of_v[0]), 32'd1);
        npop = 0;
        rdy_v[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (ov_v[0]) begin
                chk("t3_drain_data", od_v[0], 32'h102 + 32'(npop));
                npop++;
            end
            @(negedge clk);
        end
        chk("t3_drain_count", 32'(npop), 32'd4);

        // DELAY=3, DEPTH=5 streaming at full rate
        do_reset();
        rdy_v[2] = 1'b1;
        npop = 0; first_v = -1; last_v = -1; drop = 1'b0;
        for (int c = 0; c < 26; c++) begin
            go_v[2]  = (c < 20);
            din_v[2] = 32'(c - 3);
            if (c < 20 && !can_go_v[2]) drop = 1'b1;
            if (ov_v[2]) begin
                chk("t4_data", od_v[2], 32'(npop));
                if (first_v < 0) first_v = c;
                last_v = c;
                npop++;
            end
            @(negedge clk);
        end
        chk("t4_count", 32'(npop), 32'd20);
        chk("t4_first_valid", 32'(first_v), 32'd4);
        chk("t4_back_to_back", 32'(last_v - first_v), 32'd19);
        chk("t4_can_go_never_low", 32'(drop), 32'd0);
        chk("t4_overflow", 32'(of_v[2]), 32'd0);

        // Simultaneous capture/pop at occupancy 2, then wrap the pointers
        do_reset();
        npop = 0;
        for (int i = 0; i < 19; i++) begin
            go_v[0]  = (i <= 2) || (i >= 6 && i <= 10);
            din_v[0] = (i >= 2 && i <= 4) ? 32'h50 + 32'(i - 2) :
                       (i >= 8 && i <= 12) ? 32'h53 + 32'(i - 8) : 32'hDEAD;
            rdy_v[0] = (i == 4) || (i >= 6);
            if (i == 5) begin
                chk("t5_valid_occ2", 32'(ov_v[0]), 32'd1);
                chk("t5_head_after_cap_pop", od_v[0], 32'h51);
            end
            if (ov_v[0] && rdy_v[0]) begin
                chk("t5_order", od_v[0], 32'h50 + 32'(npop));
                npop++;
            end
            @(negedge clk);
        end
        chk("t5_count", 32'(npop), 32'd8);

        // Reset with two invocations in flight; late data must never appear
        do_reset();
        go_v[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        go_v[2] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_can_go", 32'(can_go_v[2]), 32'd1);
        chk("t6_overflow", 32'(of_v[2]), 32'd0);
        chk("t6_out_data", od_v[2], 32'd0);
        rdy_v[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            din_v[2] = (c < 3) ? 32'hBAD : 32'h0;
            chk("t6_no_output", 32'(ov_v[2]), 32'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
